// File: rtl/num_bomb_ctrl.sv
// Turn controller for the two-player number-bomb game: arms a secret, validates
// BCD guesses against the live (lo, hi) window, runs the LED sweep and judges.
module num_bomb_ctrl #(
    parameter int unsigned SWEEP_STEPS = 8,
    parameter int unsigned SHOW_TICKS  = 10
) (
    input  logic       clk_12MHz,
    input  logic       reset,
    input  logic       tick,
    input  logic       new_game,
    input  logic       guess_valid,
    input  logic [3:0] guess_tens,
    input  logic [3:0] guess_ones,
    output logic       active_player,
    output logic [6:0] lo,
    output logic [6:0] hi,
    output logic [7:0] led,
    output logic [1:0] result,
    output logic       guess_err,
    output logic       busy,
    output logic       game_over,
    output logic       loser
);

    localparam int unsigned SHOW_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GUESS,
        SWEEP,
        JUDGE,
        SHOW,
        OVER
    } state_t;

    state_t            state;
    logic [6:0]        rnd;
    logic [6:0]        secret;
    logic [6:0]        guess_q;
    logic [3:0]        steps_left;
    logic [SHOW_W-1:0] show_cnt;

    logic [7:0]        guess_sum;
    logic              digits_ok;
    logic              in_range;

    // 8-bit sum so out-of-range digits cannot alias into the legal window
    always_comb begin
        guess_sum = {1'b0, guess_tens, 3'b000} + {3'b000, guess_tens, 1'b0}
                  + {4'h0, guess_ones};
        digits_ok = (guess_tens <= 4'd9) && (guess_ones <= 4'd9);
        in_range  = (guess_sum > {1'b0, lo}) && (guess_sum < {1'b0, hi});
    end

    assign busy      = (state == SWEEP) || (state == JUDGE) || (state == SHOW);
    assign game_over = (state == OVER);

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            rnd <= 7'd1;
        end else begin
            rnd <= (rnd == 7'd98) ? 7'd1 : rnd + 7'd1;
        end
    end

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            active_player <= 1'b0;
            lo            <= 7'd0;
            hi            <= 7'd99;
            led           <= 8'hFF;
            result        <= 2'b00;
            guess_err     <= 1'b0;
            loser         <= 1'b0;
            secret        <= 7'd50;
            guess_q       <= '0;
            steps_left    <= '0;
            show_cnt      <= '0;
        end else begin
            guess_err <= 1'b0;
            if (new_game) begin
                secret        <= rnd;
                lo            <= 7'd0;
                hi            <= 7'd99;
                result        <= 2'b00;
                led           <= 8'hFF;
                active_player <= 1'b0;
                steps_left    <= '0;
                show_cnt      <= '0;
                state         <= WAIT_GUESS;
            end else begin
                case (state)
                    WAIT_GUESS: begin
                        if (guess_valid) begin
                            if (digits_ok && in_range) begin
                                guess_q    <= guess_sum[6:0];
                                steps_left <= 4'(SWEEP_STEPS);
                                led        <= 8'hFF;
                                state      <= SWEEP;
                            end else begin
                                guess_err <= 1'b1;
                            end
                        end
                    end
                    SWEEP: begin
                        if (tick) begin
                            if (steps_left == 4'd0) begin
                                led   <= 8'hFF;
                                state <= JUDGE;
                            end else begin
                                led        <= ~(8'd1 << (steps_left - 4'd1));
                                steps_left <= steps_left - 4'd1;
                            end
                        end
                    end
                    JUDGE: begin
                        if (guess_q > secret) begin
                            hi     <= guess_q;
                            result <= 2'b01;
                            state  <= SHOW;
                        end else if (guess_q < secret) begin
                            lo     <= guess_q;
                            result <= 2'b10;
                            state  <= SHOW;
                        end else begin
                            result <= 2'b11;
                            loser  <= active_player;
                            state  <= OVER;
                        end
                        show_cnt <= '0;
                    end
                    SHOW: begin
                        if (tick) begin
                            if (show_cnt == SHOW_W'(SHOW_TICKS - 1)) begin
                                show_cnt      <= '0;
                                result        <= 2'b00;
                                active_player <= ~active_player;
                                state         <= WAIT_GUESS;
                            end else begin
                                show_cnt <= show_cnt + 1'b1;
                            end
                        end
                    end
                    OVER: begin
                        result <= 2'b11;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_num_bomb_ctrl.sv
// Scoreboard bench for num_bomb_ctrl: stimulus queues expected output snapshots,
// a negedge monitor pops one per observable output event and compares.
module tb_num_bomb_ctrl;

    logic       clk_12MHz = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       new_game = 1'b0;
    logic       guess_valid = 1'b0;
    logic [3:0] guess_tens = '0;
    logic [3:0] guess_ones = '0;
    logic       active_player;
    logic [6:0] lo;
    logic [6:0] hi;
    logic [7:0] led;
    logic [1:0] result;
    logic       guess_err;
    logic       busy;
    logic       game_over;
    logic       loser;

    num_bomb_ctrl #(.SWEEP_STEPS(8), .SHOW_TICKS(10)) dut (
        .clk_12MHz    (clk_12MHz),
        .reset        (reset),
        .tick         (tick),
        .new_game     (new_game),
        .guess_valid  (guess_valid),
        .guess_tens   (guess_tens),
        .guess_ones   (guess_ones),
        .active_player(active_player),
        .lo           (lo),
        .hi           (hi),
        .led          (led),
        .result       (result),
        .guess_err    (guess_err),
        .busy         (busy),
        .game_over    (game_over),
        .loser        (loser)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    typedef struct packed {
        logic [1:0] res;
        logic [6:0] lo;
        logic [6:0] hi;
        logic       ap;
        logic [7:0] led;
        logic       busy;
        logic       go;
        logic       loser;
        logic       gerr;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  snap_req = 1'b0;
    logic [6:0] model_rnd;

    // reference for the free-running secret source, used only to time new_game
    always @(posedge clk_12MHz or posedge reset) begin
        if (reset) model_rnd <= 7'd1;
        else       model_rnd <= (model_rnd == 7'd98) ? 7'd1 : model_rnd + 7'd1;
    end

    function automatic snap_t mk(input logic [1:0] r, input logic [6:0] l, input logic [6:0] h,
                                 input logic a, input logic [7:0] ld, input logic b,
                                 input logic g, input logic ls, input logic ge);
        snap_t s;
        s.res = r; s.lo = l; s.hi = h; s.ap = a; s.led = ld;
        s.busy = b; s.go = g; s.loser = ls; s.gerr = ge;
        return s;
    endfunction

    // monitor: an event is a guess_err pulse, a result/led change, or a snapshot request
    logic [1:0] prev_res = 2'b00;
    logic [7:0] prev_led = 8'hFF;
    always @(negedge clk_12MHz) begin
        snap_t act, e;
        string tg;
        bit    ok;
        if (snap_req || guess_err || result != prev_res || led != prev_led) begin
            act = mk(result, lo, hi, active_player, led, busy, game_over, loser, guess_err);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got res=%0d lo=%0d hi=%0d ap=%0d led=%h busy=%0d go=%0d gerr=%0d, none required",
                         act.res, act.lo, act.hi, act.ap, act.led, act.busy, act.go, act.gerr);
            end else begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                ok = act.res == e.res && act.lo == e.lo && act.hi == e.hi && act.ap == e.ap &&
                     act.led == e.led && act.busy == e.busy && act.go == e.go &&
                     act.gerr == e.gerr && (!e.go || act.loser == e.loser);
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got res=%0d lo=%0d hi=%0d ap=%0d led=%h busy=%0d go=%0d loser=%0d gerr=%0d, required res=%0d lo=%0d hi=%0d ap=%0d led=%h busy=%0d go=%0d loser=%0d gerr=%0d",
                             tg, act.res, act.lo, act.hi, act.ap, act.led, act.busy, act.go, act.loser, act.gerr,
                             e.res, e.lo, e.hi, e.ap, e.led, e.busy, e.go, e.loser, e.gerr);
                end
            end
        end
        prev_res = result;
        prev_led = led;
    end

    task automatic push(input string tg, input snap_t s);
        exp_q.push_back(s);
        tag_q.push_back(tg);
    endtask

    task automatic push_sweep(input string tg, input logic [6:0] l, input logic [6:0] h,
                              input logic a, input int n);
        logic [7:0] one_hot;
        for (int i = 0; i < n; i++) begin
            one_hot = 8'h80 >> i;
            push(tg, mk(2'b00, l, h, a, ~one_hot, 1'b1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic snap(input string tg, input snap_t s);
        push(tg, s);
        @(posedge clk_12MHz); #1 snap_req = 1'b1;
        @(negedge clk_12MHz); #1 snap_req = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_12MHz); #1 tick = 1'b1;
            @(posedge clk_12MHz); #1 tick = 1'b0;
        end
    endtask

    task automatic guess(input logic [3:0] t, input logic [3:0] o);
        @(posedge clk_12MHz); #1 guess_valid = 1'b1; guess_tens = t; guess_ones = o;
        @(posedge clk_12MHz); #1 guess_valid = 1'b0;
    endtask

    // new_game lands on the edge that samples model_rnd == s
    task automatic arm(input logic [6:0] s);
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk_12MHz); #1;
            if (model_rnd == s) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL arm_timeout: got no secret slot, required %0d", s);
        end
        new_game = 1'b1;
        @(posedge clk_12MHz); #1 new_game = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        snap("reset", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk_12MHz); reset = 1'b0;

        // 1: secret 37, player 0 guesses 50 -> too big
        arm(7'd37);
        guess(4'd5, 4'd0);
        snap("accept50", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push_sweep("sweep50", 7'd0, 7'd99, 1'b0, 8);
        push("sweep50_end", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("big50", mk(2'b01, 7'd0, 7'd50, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("turn_p1", mk(2'b00, 7'd0, 7'd50, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_n(9);
        tick_n(10);

        // 2: player 1 guesses 20 -> too small, then boundary rejects
        guess(4'd2, 4'd0);
        push_sweep("sweep20", 7'd0, 7'd50, 1'b1, 8);
        push("sweep20_end", mk(2'b00, 7'd0, 7'd50, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("small20", mk(2'b10, 7'd20, 7'd50, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("turn_p0", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_n(9);
        tick_n(10);
        push("err_eq_hi", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd5, 4'd0);
        push("err_below_lo", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd0, 4'd9);
        push("err_eq_lo", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd2, 4'd0);

        // 3: non-BCD digits
        push("err_tens10", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd10, 4'd0);
        push("err_ones12", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd0, 4'd12);
        push("err_2_12", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
        guess(4'd2, 4'd12);
        snap("after_errs", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));

        // 4: player 0 guesses 49 (hi-1), then player 1 hits the bomb
        guess(4'd4, 4'd9);
        push_sweep("sweep49", 7'd20, 7'd50, 1'b0, 8);
        push("sweep49_end", mk(2'b00, 7'd20, 7'd50, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("big49", mk(2'b01, 7'd20, 7'd49, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("turn_p1b", mk(2'b00, 7'd20, 7'd49, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_n(9);
        tick_n(10);
        guess(4'd3, 4'd7);
        push_sweep("sweep37", 7'd20, 7'd49, 1'b1, 8);
        push("sweep37_end", mk(2'b00, 7'd20, 7'd49, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("bomb", mk(2'b11, 7'd20, 7'd49, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0));
        tick_n(9);
        guess(4'd9, 4'd9);
        guess(4'd3, 4'd0);
        tick_n(3);
        snap("over_hold", mk(2'b11, 7'd20, 7'd49, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0));

        // 5: new_game on the 4th sweep tick aborts the sweep
        push("ng_from_over", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        arm(7'd37);
        guess(4'd5, 4'd0);
        push_sweep("sweep_abort", 7'd0, 7'd99, 1'b0, 3);
        push("ng_mid_sweep", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_n(3);
        @(posedge clk_12MHz); #1 tick = 1'b1; new_game = 1'b1;
        @(posedge clk_12MHz); #1 tick = 1'b0; new_game = 1'b0;
        arm(7'd37);
        snap("rearmed", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));

        // 6: async reset mid-SHOW
        guess(4'd6, 4'd0);
        push_sweep("sweep60", 7'd0, 7'd99, 1'b0, 8);
        push("sweep60_end", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        push("big60", mk(2'b01, 7'd0, 7'd60, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
        tick_n(9);
        tick_n(3);
        push("async_reset", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk_12MHz); #2 reset = 1'b1;
        guess(4'd5, 4'd0);
        tick_n(2);
        @(posedge clk_12MHz); #1 new_game = 1'b1;
        @(posedge clk_12MHz); #1 new_game = 1'b0;
        snap("reset_held", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk_12MHz); reset = 1'b0;
        guess(4'd5, 4'd0);
        tick_n(2);
        snap("idle_ignores", mk(2'b00, 7'd0, 7'd99, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));

        repeat (5) @(posedge clk_12MHz);
        while (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_%s: got no event, required one", tag_q.pop_front());
            void'(exp_q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/num_bomb_ctrl.md
Name: num_bomb_ctrl

Overview:
Round/turn controller for the two-player number-bomb game. Arms a secret value in 1..98, alternates turns between player 0 and player 1, and validates each BCD guess against the live exclusive range (lo, hi). It sequences the 8-step LED sweep "suspense" animation, judges each guess, narrows the range, and declares the loser when the bomb is hit. Sits between the debounced button/switch front end and the seven-segment, LED and RGB display drivers.

Parameters:
SWEEP_STEPS, 8, number of tick periods in the LED sweep (1..8)
SHOW_TICKS, 10, tick periods a too-big/too-small result is held before the turn passes (>=1)

Ports:
clk_12MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle enable strobe from the 10 Hz divider; all animation timing counts ticks
new_game  in  1  one-cycle pulse: arm a new secret and start a round
guess_valid  in  1  one-cycle pulse: submit guess_tens/guess_ones for the active player
guess_tens  in  4  BCD tens digit
guess_ones  in  4  BCD ones digit
active_player  out  1  player whose turn it is
lo  out  7  exclusive lower bound, binary
hi  out  7  exclusive upper bound, binary
led  out  8  active-low sweep pattern
result  out  2  00 none, 01 too big, 10 too small, 11 bomb
guess_err  out  1  one-cycle pulse when a guess is rejected
busy  out  1  high in SWEEP, JUDGE and SHOW
game_over  out  1  high in OVER
loser  out  1  player who hit the bomb; valid while game_over

Behaviour:
- Reset (asynchronous, active-high): state IDLE; active_player=0; lo=0; hi=99; led=8'hFF; result=00; guess_err=0; loser=0; secret=50.
- Secret source: a free-running counter cycles 1..98, incrementing every clock (98 wraps to 1) and running independently of state. new_game samples it into the secret register.
- new_game has top priority in every state, including mid-sweep. On the next edge: lo=0, hi=99, result=00, led=FF, active_player=0, sweep/show counters cleared, state WAIT_GUESS.
- IDLE: ignores guess_valid.
- WAIT_GUESS, on guess_valid:
  - g = tens*10 + ones (7-bit).
  - Rejected if either digit > 9, or g <= lo, or g >= hi. A rejection pulses guess_err for exactly one cycle; state, turn and bounds are unchanged.
  - Accepted: g is latched, the step counter is loaded with SWEEP_STEPS, led=FF, state SWEEP.
  - guess_valid in any other state is ignored, with no guess_err.
- SWEEP: on each tick, led drives a single 0 at bit (steps_left-1), i.e. 8'b0111_1111 down to 8'b1111_1110 for 8 steps, and steps_left decrements. The tick that finds steps_left==0 sets led=FF and moves to JUDGE. Latency from accept to JUDGE is SWEEP_STEPS+1 ticks.
- JUDGE (exactly one cycle):
  - g > secret: hi=g, result=01, state SHOW.
  - g < secret: lo=g, result=10, state SHOW.
  - g == secret: result=11, loser=active_player, state OVER.
- SHOW: counts SHOW_TICKS ticks. On the final tick: result=00, active_player toggles, state WAIT_GUESS.
- OVER: holds result=11 and game_over=1 until new_game or reset.
- Forced bomb: when hi-lo==2, the only legal guess is the secret; no special handling is required.
- tick and guess_valid in the same cycle: the guess is accepted, and that tick is not counted toward the sweep.
- Outputs are registered; busy and game_over are decoded from state.

Test Plan:
1. Reset, force secret=37 via new_game timing, player 0 guesses 5,0 -> 9 ticks later result=01, hi=50; after 10 more ticks result=00 and active_player=1.
2. With lo=0, hi=50, player 1 guesses 2,0 -> lo=20; then guess 5,0 (==hi) and 0,9 (<lo) -> guess_err one-cycle pulse each, bounds and turn unchanged.
3. Guess digits tens=10 or ones=12 -> guess_err pulse; state stays WAIT_GUESS.
4. Secret=37, player 1 guesses 3,7 -> led walks 7F,BF,DF,EF,F7,FB,FD,FE then FF; result=11, game_over=1, loser=1; further guess_valid is ignored.
5. new_game asserted on the 4th sweep tick -> next cycle led=FF, lo=0, hi=99, active_player=0, state WAIT_GUESS.
6. reset asserted mid-SHOW, asynchronously between clock edges -> all outputs immediately take reset values; tick, new_game and guess pulses are ignored while reset is held.
